// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending (scoreboard) bit
// and a sequential clear engine that zeroes one register per cycle.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] regAddrA,
    input  logic [ADDR_WIDTH-1:0] regAddrB,
    input  logic                  regReA,
    input  logic                  regReB,
    input  logic [ADDR_WIDTH-1:0] regAddrD,
    input  logic                  regWeD,
    input  logic [DATA_WIDTH-1:0] busD,
    input  logic                  reserveEn,
    input  logic [ADDR_WIDTH-1:0] reserveAddr,
    input  logic                  clearReq,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    output logic                  validA,
    output logic                  validB,
    output logic                  busy
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]     pend_q;
    logic [NUM_REGS-1:0]     pend_d;
    logic [DATA_WIDTH-1:0]   busA_q, busB_q;
    logic                    validA_q, validB_q;

    logic                    idle;
    logic                    we_eff;
    logic                    res_eff;
    logic                    clear_last;
    logic [DATA_WIDTH-1:0]   rd_a, rd_b;

    always_comb begin
        idle       = (state_q == IDLE);
        we_eff     = idle && regWeD && !(ZERO_REG && (regAddrD == '0));
        res_eff    = idle && reserveEn && !(ZERO_REG && (reserveAddr == '0));
        clear_last = !idle && (cnt_q == LAST_ADDR);

        // Reservation is applied after the write so a same-edge pair leaves the bit set.
        pend_d = pend_q;
        if (we_eff) pend_d[regAddrD] = 1'b0;
        if (res_eff) pend_d[reserveAddr] = 1'b1;
        if (clear_last) pend_d = '0;

        // Reads observe the post-edge value, so a same-edge write is bypassed.
        rd_a = (we_eff && (regAddrA == regAddrD)) ? busD : regs_q[regAddrA];
        rd_b = (we_eff && (regAddrB == regAddrD)) ? busD : regs_q[regAddrB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pend_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            busA_q   <= '0;
            busB_q   <= '0;
            validA_q <= 1'b0;
            validB_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (we_eff) regs_q[regAddrD] <= busD;

            busA_q   <= (idle && regReA) ? rd_a : '0;
            busB_q   <= (idle && regReB) ? rd_b : '0;
            validA_q <= idle && regReA && !pend_d[regAddrA];
            validB_q <= idle && regReB && !pend_d[regAddrB];

            case (state_q)
                IDLE: begin
                    if (clearReq) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    regs_q[cnt_q] <= '0;
                    if (clear_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busA   = busA_q;
    assign busB   = busB_q;
    assign validA = validA_q;
    assign validB = validB_q;
    assign busy   = (state_q == CLEAR);

endmodule
